// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, state, alu_op and display-mode encodings for the calculator
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'd10;
    localparam logic [4:0] KEY_SUB = 5'd11;
    localparam logic [4:0] KEY_MUL = 5'd12;
    localparam logic [4:0] KEY_DIV = 5'd13;
    localparam logic [4:0] KEY_EQ  = 5'd14;
    localparam logic [4:0] KEY_MEM = 5'd15;

    // Largest value a 3-digit operand can hold; recall and chaining refuse anything bigger.
    localparam int MAX_VALUE = 999;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_EXEC,
        ST_SHOW,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        DISP_OPERAND  = 2'd0,
        DISP_OPERATOR = 2'd1,
        DISP_RESULT   = 2'd2,
        DISP_ERROR    = 2'd3
    } disp_mode_e;

endpackage

// File: rtl/calc_operand_acc.sv
// rtl/calc_operand_acc.sv - decimal operand accumulator (acc*10+digit) with saturating digit count
module calc_operand_acc #(
    parameter int OPW        = 10,
    parameter int MAX_DIGITS = 3,
    parameter int CNTW       = $clog2(MAX_DIGITS + 1)
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            clear,
    input  logic            load_digit,
    input  logic [3:0]      digit,
    input  logic            load_value,
    input  logic [OPW-1:0]  value,
    output logic [OPW-1:0]  acc,
    output logic [CNTW-1:0] cnt
);

    logic [OPW-1:0]  acc_q, acc_d, base_acc;
    logic [CNTW-1:0] cnt_q, cnt_d, base_cnt;

    // clear combined with load_digit starts a fresh operand holding just that digit
    always_comb begin
        base_acc = clear ? '0 : acc_q;
        base_cnt = clear ? '0 : cnt_q;
        acc_d    = base_acc;
        cnt_d    = base_cnt;
        if (load_value) begin
            acc_d = value;
            cnt_d = CNTW'(MAX_DIGITS);
        end else if (load_digit && (base_cnt < CNTW'(MAX_DIGITS))) begin
            acc_d = base_acc * OPW'(10) + OPW'(digit);
            cnt_d = base_cnt + 1'b1;
        end
    end

    // operand registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc = acc_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad calculator controller; define CALC_CHAIN_EN to chain an operator after a result
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int OPW        = 10,
    parameter int RESW       = 20,
    parameter int MAX_DIGITS = 3,
    parameter int IDLE_CODE  = 31
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic [4:0]      key_code,
    output logic            alu_start,
    output logic [1:0]      alu_op,
    output logic [OPW-1:0]  alu_a,
    output logic [OPW-1:0]  alu_b,
    input  logic            alu_done,
    input  logic [RESW-1:0] alu_result,
    output logic [RESW-1:0] disp_value,
    output logic [1:0]      disp_mode,
    output logic            busy,
    output logic            err
);

    localparam int         CNTW = $clog2(MAX_DIGITS + 1);
    localparam logic [4:0] IDLE = 5'(IDLE_CODE);

    state_e          state_q, state_d;
    logic [4:0]      key_prev_q, key_prev_d;
    logic [OPW-1:0]  a_q, a_d;
    alu_op_e         op_q, op_d;
    logic [RESW-1:0] result_q, result_d;
    logic [RESW-1:0] mem_q, mem_d;
    logic            first_q, first_d;
    logic [OPW-1:0]  alu_a_q, alu_a_d;
    logic [OPW-1:0]  alu_b_q, alu_b_d;
    alu_op_e         alu_op_q, alu_op_d;

    logic            acc_clear, acc_load_digit, acc_load_value;
    logic [OPW-1:0]  acc;
    logic [CNTW-1:0] cnt;

    logic            press, key_is_digit, key_is_op, key_is_eq, key_is_mem;
    logic            mem_ok, div_zero, sub_neg;
    alu_op_e         key_op;

    // one shared accumulator serves A entry, then B entry
    calc_operand_acc #(
        .OPW        (OPW),
        .MAX_DIGITS (MAX_DIGITS),
        .CNTW       (CNTW)
    ) u_acc (
        .clk_in     (clk_in),
        .reset      (reset),
        .clear      (acc_clear),
        .load_digit (acc_load_digit),
        .digit      (key_code[3:0]),
        .load_value (acc_load_value),
        .value      (mem_q[OPW-1:0]),
        .acc        (acc),
        .cnt        (cnt)
    );

    // key classification and press-edge detection
    always_comb begin
        key_prev_d   = key_code;
        press        = (key_code != IDLE) && (key_prev_q == IDLE);
        key_is_digit = key_code <= 5'd9;
        key_is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
        key_is_eq    = key_code == KEY_EQ;
        key_is_mem   = key_code == KEY_MEM;
        key_op       = alu_op_e'(2'(key_code - KEY_ADD));
        mem_ok       = ((mem_q >> OPW) == '0) && (mem_q <= RESW'(MAX_VALUE));
        div_zero     = (op_q == OP_DIV) && (acc == '0);
        sub_neg      = (op_q == OP_SUB) && (acc > a_q);
    end

    // next-state and datapath control
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        op_d           = op_q;
        result_d       = result_q;
        mem_d          = mem_q;
        first_d        = 1'b0;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        acc_clear      = 1'b0;
        acc_load_digit = 1'b0;
        acc_load_value = 1'b0;
        case (state_q)
            ST_ENTER_A, ST_ENTER_B: begin
                if (press) begin
                    if (key_is_digit) begin
                        acc_load_digit = 1'b1;
                    end else if (key_is_op) begin
                        if (state_q == ST_ENTER_B) begin
                            op_d = key_op;
                        end else if (cnt != '0) begin
                            a_d       = acc;
                            op_d      = key_op;
                            acc_clear = 1'b1;
                            state_d   = ST_ENTER_B;
                        end
                    end else if (key_is_eq) begin
                        if ((state_q == ST_ENTER_B) && (cnt != '0)) begin
                            if (div_zero || sub_neg) begin
                                state_d = ST_ERROR;
                            end else begin
                                state_d  = ST_EXEC;
                                first_d  = 1'b1;
                                alu_a_d  = a_q;
                                alu_b_d  = acc;
                                alu_op_d = op_q;
                            end
                        end
                    end else if (key_is_mem) begin
                        if (mem_ok) acc_load_value = 1'b1;
                        else        state_d = ST_ERROR;
                    end
                end
            end
            ST_EXEC: begin
                // a done pulse coinciding with the start pulse cannot belong to this operation
                if (alu_done && !first_q) begin
                    result_d = alu_result;
                    mem_d    = alu_result;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW, ST_ERROR: begin
                if (press) begin
                    if (key_is_digit) begin
                        acc_clear      = 1'b1;
                        acc_load_digit = 1'b1;
                        state_d        = ST_ENTER_A;
                    end else if (key_is_mem) begin
                        if (mem_ok) begin
                            acc_load_value = 1'b1;
                            state_d        = ST_ENTER_A;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
`ifdef CALC_CHAIN_EN
                    else if (key_is_op && (state_q == ST_SHOW)) begin
                        if (result_q <= RESW'(MAX_VALUE)) begin
                            a_d       = result_q[OPW-1:0];
                            op_d      = key_op;
                            acc_clear = 1'b1;
                            state_d   = ST_ENTER_B;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
`endif
                end
            end
            default: state_d = ST_ENTER_A;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_ENTER_A;
            key_prev_q <= IDLE;
            a_q        <= '0;
            op_q       <= OP_ADD;
            result_q   <= '0;
            mem_q      <= '0;
            first_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= OP_ADD;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            a_q        <= a_d;
            op_q       <= op_d;
            result_q   <= result_d;
            mem_q      <= mem_d;
            first_q    <= first_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
        end
    end

    // ALU handshake, status and display outputs
    always_comb begin
        alu_start  = (state_q == ST_EXEC) && first_q;
        busy       = state_q == ST_EXEC;
        err        = state_q == ST_ERROR;
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        alu_op     = alu_op_q;
        disp_value = RESW'(acc);
        disp_mode  = DISP_OPERAND;
        case (state_q)
            ST_ENTER_B: if (cnt == '0) disp_mode = DISP_OPERATOR;
            ST_SHOW: begin
                disp_value = result_q;
                disp_mode  = DISP_RESULT;
            end
            ST_ERROR: begin
                disp_value = '0;
                disp_mode  = DISP_ERROR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer with a behavioural calculator model
module tb_calc_sequencer;

    localparam int PH_A    = 0;
    localparam int PH_B    = 1;
    localparam int PH_EXEC = 2;
    localparam int PH_SHOW = 3;
    localparam int PH_ERR  = 4;
    localparam logic [4:0] K_IDLE = 5'd31;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  key_code = 5'd31;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [9:0]  alu_a, alu_b;
    logic        alu_done = 1'b0;
    logic [19:0] alu_result = '0;
    logic [19:0] disp_value;
    logic [1:0]  disp_mode;
    logic        busy, err;

    int checks = 0;
    int errors = 0;

    // ALU emulation knobs
    int          alu_lat = 3;
    logic [19:0] alu_value = '0;
    bit          alu_early = 1'b0;

    // start pulses observed on the DUT
    int start_count = 0;
    int last_a = 0, last_b = 0, last_op = 0;

    // behavioural model state
    int m_ph = PH_A, m_acc = 0, m_cnt = 0, m_a = 0, m_op = 0;
    int m_res = 0, m_mem = 0, m_prev = 31;
    int m_xa = 0, m_xb = 0, m_xop = 0;
    bit m_first = 1'b0;

    calc_sequencer dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .key_code   (key_code),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .disp_value (disp_value),
        .disp_mode  (disp_mode),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // calculator rules applied to one key press
    task automatic model_key(input int k);
        bit entry;
        entry = (m_ph == PH_A) || (m_ph == PH_B);
        if (k <= 9) begin
            if (entry) begin
                if (m_cnt < 3) begin
                    m_acc = m_acc * 10 + k;
                    m_cnt++;
                end
            end else begin
                m_acc = k;
                m_cnt = 1;
                m_ph  = PH_A;
            end
        end else if (k <= 13) begin
            if (m_ph == PH_A && m_cnt > 0) begin
                m_a = m_acc; m_op = k - 10; m_acc = 0; m_cnt = 0; m_ph = PH_B;
            end else if (m_ph == PH_B) begin
                m_op = k - 10;
            end
`ifdef CALC_CHAIN_EN
            else if (m_ph == PH_SHOW) begin
                if (m_res <= 999) begin
                    m_a = m_res; m_op = k - 10; m_acc = 0; m_cnt = 0; m_ph = PH_B;
                end else begin
                    m_ph = PH_ERR;
                end
            end
`endif
        end else if (k == 14) begin
            if (m_ph == PH_B && m_cnt > 0) begin
                if ((m_op == 3 && m_acc == 0) || (m_op == 1 && m_acc > m_a)) begin
                    m_ph = PH_ERR;
                end else begin
                    m_ph = PH_EXEC; m_first = 1'b1;
                    m_xa = m_a; m_xb = m_acc; m_xop = m_op;
                end
            end
        end else if (k == 15) begin
            if (m_mem <= 999) begin
                m_acc = m_mem; m_cnt = 3;
                if (!entry) m_ph = PH_A;
            end else begin
                m_ph = PH_ERR;
            end
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_ph = PH_A; m_acc = 0; m_cnt = 0; m_a = 0; m_op = 0;
            m_res = 0; m_mem = 0; m_prev = 31; m_first = 1'b0;
            m_xa = 0; m_xb = 0; m_xop = 0;
            return;
        end
        if (m_ph == PH_EXEC) begin
            if (alu_done && !m_first) begin
                m_res = 32'(alu_result);
                m_mem = 32'(alu_result);
                m_ph  = PH_SHOW;
            end
            m_first = 1'b0;
        end else if (key_code != K_IDLE && m_prev == 31) begin
            model_key(32'(key_code));
        end
        m_prev = 32'(key_code);
    endtask

    function automatic int exp_value();
        if (m_ph == PH_SHOW) return m_res;
        if (m_ph == PH_ERR)  return 0;
        return m_acc;
    endfunction

    function automatic int exp_mode();
        if (m_ph == PH_SHOW) return 2;
        if (m_ph == PH_ERR)  return 3;
        if (m_ph == PH_B && m_cnt == 0) return 1;
        return 0;
    endfunction

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk_in);
        chk("alu_start", 32'(alu_start), 32'(m_ph == PH_EXEC && m_first));
        chk("busy", 32'(busy), 32'(m_ph == PH_EXEC));
        chk("err", 32'(err), 32'(m_ph == PH_ERR));
        if (m_ph != PH_EXEC) begin
            chk("disp_value", 32'(disp_value), exp_value());
            chk("disp_mode", 32'(disp_mode), exp_mode());
        end else begin
            chk("alu_a", 32'(alu_a), m_xa);
            chk("alu_b", 32'(alu_b), m_xb);
            chk("alu_op", 32'(alu_op), m_xop);
        end
        if (alu_start) begin
            start_count++;
            last_a = 32'(alu_a); last_b = 32'(alu_b); last_op = 32'(alu_op);
        end
    end

    // ALU responder: optional stray done in the start cycle, real done alu_lat cycles later
    initial forever begin
        @(negedge clk_in);
        if (alu_start) begin
            if (alu_early) begin
                #1;
                alu_done = 1'b1;
                alu_result = 20'd777;
            end
            repeat (alu_lat) begin
                @(posedge clk_in);
                #1;
                alu_done = 1'b0;
            end
            alu_done = 1'b1;
            alu_result = alu_value;
            @(posedge clk_in);
            #1;
            alu_done = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press_key(input logic [4:0] k, input int hold);
        key_code = k;
        repeat (hold) @(posedge clk_in);
        #1;
        key_code = K_IDLE;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_disp_value", 32'(disp_value), 0);
        chk("rst_disp_mode", 32'(disp_mode), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_flags", 32'({alu_start, busy, err}), 0);
        reset = 1'b0;
        idle(1);

        // 123 + 45 = 168, ALU takes 3 cycles
        alu_lat = 3; alu_value = 20'd168;
        press_key(5'd1, 1); press_key(5'd2, 1); press_key(5'd3, 1);
        press_key(5'd10, 1);
        chk("op_mode", 32'(disp_mode), 1);
        press_key(5'd4, 1); press_key(5'd5, 1);
        press_key(5'd14, 1);
        idle(8);
        chk("add_starts", start_count, 1);
        chk("add_a", last_a, 123);
        chk("add_b", last_b, 45);
        chk("add_op", last_op, 0);
        chk("add_disp", 32'(disp_value), 168);
        chk("add_mode", 32'(disp_mode), 2);
        chk("model_mem", m_mem, 168);
        press_key(5'd15, 1);
        chk("recall_168", 32'(disp_value), 168);

        // held key counts once; digits beyond three are dropped
        do_reset();
        press_key(5'd5, 10);
        press_key(5'd5, 1);
        chk("held_55", 32'(disp_value), 55);
        press_key(5'd1, 1);
        press_key(5'd2, 1);
        chk("sat_551", 32'(disp_value), 551);
        do_reset();
        press_key(5'd1, 1); press_key(5'd2, 1); press_key(5'd3, 1);
        press_key(5'd4, 1); press_key(5'd5, 1);
        chk("sat_123", 32'(disp_value), 123);

        // 9 / 0 -> error, then a digit restarts entry
        do_reset();
        press_key(5'd9, 1); press_key(5'd13, 1); press_key(5'd0, 1);
        press_key(5'd14, 1);
        idle(3);
        chk("div0_err", 32'(err), 1);
        chk("div0_mode", 32'(disp_mode), 3);
        chk("div0_starts", start_count, 1);
        press_key(5'd7, 1);
        chk("after_err_val", 32'(disp_value), 7);
        chk("after_err_err", 32'(err), 0);

        // 3 - 8 -> error; 999 * 999 with a stray early done; recall of 998001 -> error
        do_reset();
        press_key(5'd3, 1); press_key(5'd11, 1); press_key(5'd8, 1);
        press_key(5'd14, 1);
        chk("neg_err", 32'(err), 1);
        alu_lat = 2; alu_value = 20'd998001; alu_early = 1'b1;
        for (int i = 0; i < 3; i++) press_key(5'd9, 1);
        press_key(5'd12, 1);
        for (int i = 0; i < 3; i++) press_key(5'd9, 1);
        press_key(5'd14, 1);
        idle(8);
        alu_early = 1'b0;
        chk("mul_starts", start_count, 2);
        chk("mul_disp", 32'(disp_value), 998001);
        chk("mul_mode", 32'(disp_mode), 2);
        press_key(5'd15, 1);
        chk("big_recall_err", 32'(err), 1);

        // reset during the second EXEC cycle; the late done must be ignored
        do_reset();
        alu_lat = 3; alu_value = 20'd3;
        press_key(5'd1, 1); press_key(5'd10, 1); press_key(5'd2, 1);
        press_key(5'd14, 1);
        do_reset();
        idle(5);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_disp", 32'(disp_value), 0);
        chk("abort_mode", 32'(disp_mode), 0);
        chk("abort_alu_a", 32'(alu_a), 0);
        press_key(5'd15, 1);
        press_key(5'd5, 1);
        chk("abort_mem0", 32'(disp_value), 0);
        chk("abort_starts", start_count, 3);

        // 2 + 3 = 5, then * 4 =
        do_reset();
        alu_lat = 2; alu_value = 20'd5;
        press_key(5'd2, 1); press_key(5'd10, 1); press_key(5'd3, 1);
        press_key(5'd14, 1);
        idle(6);
        chk("chain_first", 32'(disp_value), 5);
        alu_value = 20'd20;
        press_key(5'd12, 1); press_key(5'd4, 1); press_key(5'd14, 1);
        idle(8);
`ifdef CALC_CHAIN_EN
        chk("chain_starts", start_count, 5);
        chk("chain_a", last_a, 5);
        chk("chain_b", last_b, 4);
        chk("chain_op", last_op, 2);
        chk("chain_disp", 32'(disp_value), 20);
`else
        chk("nochain_starts", start_count, 4);
        chk("nochain_disp", 32'(disp_value), 4);
        chk("nochain_mode", 32'(disp_mode), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
